txpippm_step_sequencer: RTL

Issuing end of the TX phase-interpolator PPM step interface: generates the per-step pulse, channel select and step size consumed by the TX PPM controllers. Accepts a step command (channel mask, direction, magnitude, step count, gap) over a valid/ready handshake and emits exactly that many pulses with guaranteed high and low widths. pulse_out crosses into the TXUSRCLK domain. sel_out and stepsize_out are therefore held constant for the whole command, including the trailing gap. Sits in the free-running clock domain next to the reset helper and is driven by the debug/VIO or PPM-tracking logic.

---
 rtl/txpippm_step_sequencer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/txpippm_step_sequencer.sv
// TX PPM step sequencer: turns one accepted step command into N pulses of fixed high
// width and clamped gap, holding channel select and step size constant for the whole command.
module txpippm_step_sequencer #(
  parameter int CHANNEL_COUNT  = 10,
  parameter int COUNT_WIDTH    = 16,
  parameter int HIGH_CYCLES    = 8,
  parameter int MIN_GAP_CYCLES = 8
) (
  input  logic                     clk_in,
  input  logic                     reset_n_in,
  input  logic                     cmd_valid_in,
  output logic                     cmd_ready_out,
  input  logic [CHANNEL_COUNT-1:0] cmd_sel_in,
  input  logic                     cmd_dir_in,
  input  logic [3:0]               cmd_mag_in,
  input  logic [COUNT_WIDTH-1:0]   cmd_count_in,
  input  logic [COUNT_WIDTH-1:0]   cmd_gap_in,
  input  logic                     abort_in,
  output logic                     pulse_out,
  output logic [CHANNEL_COUNT-1:0] sel_out,
  output logic [4:0]               stepsize_out,
  output logic [COUNT_WIDTH-1:0]   remaining_out,
  output logic                     busy_out,
  output logic                     done_out,
  output logic                     aborted_out
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HIGH   = 2'd1,
    S_GAP    = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] L_ZERO      = COUNT_WIDTH'(0);
  localparam logic [COUNT_WIDTH-1:0] L_ONE       = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] L_HIGH_LAST = COUNT_WIDTH'(HIGH_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] L_MIN_GAP   = COUNT_WIDTH'(MIN_GAP_CYCLES);

  state_t                   r_state;
  state_t                   w_next_state;
  logic [COUNT_WIDTH-1:0]   r_cnt;
  logic [COUNT_WIDTH-1:0]   r_gap;
  logic [COUNT_WIDTH-1:0]   r_remaining;
  logic [CHANNEL_COUNT-1:0] r_sel;
  logic [4:0]               r_stepsize;
  logic                     r_abort_pend;
  logic                     r_ready;
  logic                     r_pulse;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_aborted;

  logic                     w_accept;
  logic                     w_abort_now;
  logic [COUNT_WIDTH-1:0]   w_gap_clamped;

  assign w_gap_clamped = (cmd_gap_in < L_MIN_GAP) ? L_MIN_GAP : cmd_gap_in;

  // Next-state decode; abort only counts while a pulse or gap is in flight.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_abort_now  = r_abort_pend;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid_in && r_ready) begin
          w_accept     = 1'b1;
          w_next_state = (cmd_count_in == L_ZERO) ? S_FINISH : S_HIGH;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_HIGH: begin
        w_abort_now = r_abort_pend | abort_in;
        if (r_cnt == L_HIGH_LAST) begin
          w_next_state = S_GAP;
        end else begin
          w_next_state = S_HIGH;
        end
      end
      S_GAP: begin
        w_abort_now = r_abort_pend | abort_in;
        if (r_cnt == (r_gap - L_ONE)) begin
          if ((r_remaining != L_ZERO) && !w_abort_now) begin
            w_next_state = S_HIGH;
          end else begin
            w_next_state = S_FINISH;
          end
        end else begin
          w_next_state = S_GAP;
        end
      end
      S_FINISH: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State, command latches and registered outputs.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_state      <= S_IDLE;
      r_cnt        <= L_ZERO;
      r_gap        <= L_ZERO;
      r_remaining  <= L_ZERO;
      r_sel        <= {CHANNEL_COUNT{1'b0}};
      r_stepsize   <= 5'd0;
      r_abort_pend <= 1'b0;
      r_ready      <= 1'b0;
      r_pulse      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= (w_next_state != r_state) ? L_ZERO : (r_cnt + L_ONE);
      if (w_accept) begin
        r_sel       <= cmd_sel_in;
        r_stepsize  <= {cmd_dir_in, cmd_mag_in};
        r_gap       <= w_gap_clamped;
        r_remaining <= (cmd_count_in == L_ZERO) ? L_ZERO : (cmd_count_in - L_ONE);
      end else if ((r_state == S_GAP) && (w_next_state == S_HIGH)) begin
        r_remaining <= r_remaining - L_ONE;
      end else begin
        r_remaining <= r_remaining;
      end
      r_abort_pend <= (r_state == S_FINISH) ? 1'b0 : w_abort_now;
      r_ready      <= (w_next_state == S_IDLE);
      r_pulse      <= (w_next_state == S_HIGH);
      r_busy       <= (w_next_state != S_IDLE);
      r_done       <= (w_next_state == S_FINISH);
      r_aborted    <= (w_next_state == S_FINISH) && w_abort_now;
    end
  end

  assign cmd_ready_out = r_ready;
  assign pulse_out     = r_pulse;
  assign sel_out       = r_sel;
  assign stepsize_out  = r_stepsize;
  assign remaining_out = r_remaining;
  assign busy_out      = r_busy;
  assign done_out      = r_done;
  assign aborted_out   = r_aborted;

endmodule
